// File: rtl/tri_raster_scan.sv
// Triangle rasteriser: accepts three vertices and streams every enclosed lattice
// point in raster order using incremental edge functions, with output backpressure.
module tri_raster_scan #(
  parameter int CW = 3,
  parameter int EW = 2*CW+4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y1,
  input  logic [CW-1:0] x2,
  input  logic [CW-1:0] y2,
  input  logic          edge_incl,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] xo,
  output logic [CW-1:0] yo,
  output logic          busy,
  output logic          done,
  output logic [2*CW:0] pt_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] ROW   = 3'd2;
  localparam logic [2:0] SCAN  = 3'd3;
  localparam logic [2:0] FLUSH = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic signed [EW-1:0] ZERO  = {EW{1'b0}};
  localparam logic [CW:0]          ONE_C = {{CW{1'b0}}, 1'b1};
  localparam logic [2*CW:0]        ONE_P = {{(2*CW){1'b0}}, 1'b1};

  function automatic logic signed [EW-1:0] ext(input logic [CW:0] v);
    return $signed({{(EW-CW-1){1'b0}}, v});
  endfunction

  function automatic logic signed [EW-1:0] edge_c(input logic [CW-1:0] xi, yi, xj, yj);
    return ext({1'b0, xi}) * ext({1'b0, yj}) - ext({1'b0, xj}) * ext({1'b0, yi});
  endfunction

  function automatic logic [CW-1:0] min3(input logic [CW-1:0] p, q, r);
    logic [CW-1:0] m;
    m = (p < q) ? p : q;
    return (r < m) ? r : m;
  endfunction

  function automatic logic [CW-1:0] max3(input logic [CW-1:0] p, q, r);
    logic [CW-1:0] m;
    m = (p > q) ? p : q;
    return (r > m) ? r : m;
  endfunction

  logic [2:0]             st_r, nxt_s;
  logic [CW-1:0]          vx_r [3];
  logic [CW-1:0]          vy_r [3];
  logic                   incl_r;
  logic signed [EW-1:0]   a_r [3];
  logic signed [EW-1:0]   b_r [3];
  logic signed [EW-1:0]   c_r [3];
  logic signed [EW-1:0]   e_r [3];
  logic signed [EW-1:0]   sa_s [3];
  logic signed [EW-1:0]   sb_s [3];
  logic signed [EW-1:0]   sc_s [3];
  logic signed [EW-1:0]   re_s [3];
  logic signed [EW-1:0]   area_s;
  logic [CW:0]            x_r, y_r, xmin_r, xmax_r, ymax_r;
  logic                   accept_s, stall_s, inside_s, row_end_s, last_row_s;

  assign accept_s   = (st_r == IDLE) && in_valid && in_ready;
  assign stall_s    = out_valid && !out_ready;
  assign row_end_s  = (x_r == xmax_r);
  assign last_row_s = (y_r == ymax_r);

  // Edge k runs from vertex k to vertex k+1 (mod 3)
  assign sa_s[0] = ext({1'b0, vy_r[0]}) - ext({1'b0, vy_r[1]});
  assign sb_s[0] = ext({1'b0, vx_r[1]}) - ext({1'b0, vx_r[0]});
  assign sc_s[0] = edge_c(vx_r[0], vy_r[0], vx_r[1], vy_r[1]);
  assign sa_s[1] = ext({1'b0, vy_r[1]}) - ext({1'b0, vy_r[2]});
  assign sb_s[1] = ext({1'b0, vx_r[2]}) - ext({1'b0, vx_r[1]});
  assign sc_s[1] = edge_c(vx_r[1], vy_r[1], vx_r[2], vy_r[2]);
  assign sa_s[2] = ext({1'b0, vy_r[2]}) - ext({1'b0, vy_r[0]});
  assign sb_s[2] = ext({1'b0, vx_r[0]}) - ext({1'b0, vx_r[2]});
  assign sc_s[2] = edge_c(vx_r[2], vy_r[2], vx_r[0], vy_r[0]);
  assign area_s  = sa_s[0] * ext({1'b0, vx_r[2]}) + sb_s[0] * ext({1'b0, vy_r[2]}) + sc_s[0];

  // Edge values at the start of the current row
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      re_s[k] = a_r[k] * ext(xmin_r) + b_r[k] * ext(y_r) + c_r[k];
    end
  end

  // Inside test for the pixel under evaluation
  always_comb begin
    if (incl_r) begin
      inside_s = (e_r[0] >= ZERO) && (e_r[1] >= ZERO) && (e_r[2] >= ZERO);
    end else begin
      inside_s = (e_r[0] > ZERO) && (e_r[1] > ZERO) && (e_r[2] > ZERO);
    end
  end

  // Next-state selection
  always_comb begin
    nxt_s = st_r;
    case (st_r)
      IDLE:  nxt_s = accept_s ? SETUP : IDLE;
      SETUP: nxt_s = (area_s == ZERO) ? DONE : ROW;
      ROW:   nxt_s = SCAN;
      SCAN: begin
        if (stall_s) begin
          nxt_s = SCAN;
        end else if (row_end_s) begin
          nxt_s = last_row_s ? FLUSH : ROW;
        end else begin
          nxt_s = SCAN;
        end
      end
      FLUSH: nxt_s = (!out_valid || out_ready) ? DONE : FLUSH;
      DONE:  nxt_s = IDLE;
      default: nxt_s = IDLE;
    endcase
  end

  // State, job parameters and scan datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_r   <= IDLE;
      incl_r <= 1'b0;
      x_r    <= {(CW+1){1'b0}};
      y_r    <= {(CW+1){1'b0}};
      xmin_r <= {(CW+1){1'b0}};
      xmax_r <= {(CW+1){1'b0}};
      ymax_r <= {(CW+1){1'b0}};
      for (int k = 0; k < 3; k++) begin
        vx_r[k] <= {CW{1'b0}};
        vy_r[k] <= {CW{1'b0}};
        a_r[k]  <= ZERO;
        b_r[k]  <= ZERO;
        c_r[k]  <= ZERO;
        e_r[k]  <= ZERO;
      end
    end else begin
      st_r <= nxt_s;
      case (st_r)
        IDLE: begin
          if (accept_s) begin
            vx_r[0] <= x0; vy_r[0] <= y0;
            vx_r[1] <= x1; vy_r[1] <= y1;
            vx_r[2] <= x2; vy_r[2] <= y2;
            incl_r  <= edge_incl;
          end
        end
        SETUP: begin
          xmin_r <= {1'b0, min3(vx_r[0], vx_r[1], vx_r[2])};
          xmax_r <= {1'b0, max3(vx_r[0], vx_r[1], vx_r[2])};
          ymax_r <= {1'b0, max3(vy_r[0], vy_r[1], vy_r[2])};
          y_r    <= {1'b0, min3(vy_r[0], vy_r[1], vy_r[2])};
          // Clockwise winding: flip every edge so inside is always E >= 0
          for (int k = 0; k < 3; k++) begin
            a_r[k] <= (area_s < ZERO) ? -sa_s[k] : sa_s[k];
            b_r[k] <= (area_s < ZERO) ? -sb_s[k] : sb_s[k];
            c_r[k] <= (area_s < ZERO) ? -sc_s[k] : sc_s[k];
          end
        end
        ROW: begin
          x_r <= xmin_r;
          for (int k = 0; k < 3; k++) begin
            e_r[k] <= re_s[k];
          end
        end
        SCAN: begin
          if (!stall_s) begin
            x_r <= x_r + ONE_C;
            for (int k = 0; k < 3; k++) begin
              e_r[k] <= e_r[k] + a_r[k];
            end
            if (row_end_s && !last_row_s) begin
              y_r <= y_r + ONE_C;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      xo        <= {CW{1'b0}};
      yo        <= {CW{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      pt_count  <= {(2*CW+1){1'b0}};
    end else begin
      in_ready <= (nxt_s == IDLE);
      done     <= (st_r == DONE);
      case (st_r)
        IDLE: begin
          if (accept_s) begin
            busy     <= 1'b1;
            pt_count <= {(2*CW+1){1'b0}};
          end
        end
        SCAN: begin
          if (!stall_s) begin
            if (inside_s) begin
              out_valid <= 1'b1;
              xo        <= x_r[CW-1:0];
              yo        <= y_r[CW-1:0];
              pt_count  <= pt_count + ONE_P;
            end else begin
              out_valid <= 1'b0;
            end
          end
        end
        ROW, FLUSH: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          xo        <= {CW{1'b0}};
          yo        <= {CW{1'b0}};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/tri_raster_scan.md
Name: tri_raster_scan

Overview:
- Parametrised triangle rasteriser. It accepts three vertices through a valid/ready handshake and streams every lattice point inside the triangle, in raster order (y ascending, then x ascending).
- Successor to the fixed 3-bit coordinate generator. Adds:
  - generic coordinate width;
  - either vertex winding;
  - inclusive or strict edge mode;
  - output backpressure;
  - a point counter.
- Sits between the vertex memory front-end and the point consumer in the coordinate calculator subsystem.

Parameters:
- CW, 3: coordinate width in bits. Coordinates are unsigned, range 0..2^CW-1.
- EW, 2*CW+4: signed width of the edge-function accumulators.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  vertex set valid.
- in_ready  out  1  block idle and able to accept a vertex set.
- x0, y0, x1, y1, x2, y2  in  CW each  vertex coordinates. Sampled only on accept.
- edge_incl  in  1  1 = points on an edge count as inside; 0 = strict interior only. Sampled on accept.
- out_valid  out  1  xo/yo holds a point.
- out_ready  in  1  consumer accepts the point.
- xo, yo  out  CW each  point coordinates.
- busy  out  1  a job is in progress, from accept to done.
- done  out  1  one-cycle pulse at job end.
- pt_count  out  2*CW+1  number of points emitted by the current or last job.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE;
  - in_ready=0 while reset is asserted, then 1 in IDLE;
  - out_valid=0, busy=0, done=0, xo=0, yo=0, pt_count=0.
  - Reset mid-job aborts the job immediately. No further points are emitted.
- States: IDLE -> SETUP -> ROW -> SCAN -> (ROW | FLUSH) -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid & in_ready: latch the vertices and edge_incl, clear pt_count, set busy=1, go to SETUP.
- SETUP (1 cycle):
  - Compute the bounding box xmin/xmax/ymin/ymax.
  - For edges (v0,v1), (v1,v2), (v2,v0) compute a=yi-yj, b=xj-xi, c=xi*yj-xj*yi. All values are sign-extended to EW.
  - Compute area = E01(v2).
  - If area==0 (collinear or coincident vertices), go to DONE; the job emits no points.
  - If area<0, negate all a, b, c so that inside is always E>=0.
- ROW (1 cycle):
  - Load E_k = a_k*xmin + b_k*y + c_k for k=0..2, with y starting at ymin.
  - Set x=xmin.
- SCAN (one pixel per cycle unless stalled):
  - Pixel is inside if all E_k>=0 (edge_incl=1) or all E_k>0 (edge_incl=0).
  - Inside pixel: register xo=x, yo=y, out_valid=1, and increment pt_count.
  - Then x++ and E_k+=a_k.
  - Stall: while out_valid & !out_ready, SCAN holds x, E and the outputs stable. No pixel is evaluated.
  - When out_valid & out_ready and no new inside pixel is produced, out_valid clears.
  - End of row (x==xmax evaluated): if y==ymax go to FLUSH, else y++ and go to ROW.
- FLUSH: wait until out_valid is 0, meaning the last point has been accepted.
- DONE (1 cycle):
  - done=1, busy=0, xo=yo=0.
  - Next cycle: IDLE and in_ready=1.
- Latency:
  - If the first inside pixel is at (xmin,ymin), out_valid rises in cycle accept+3.
  - Row overhead is 1 cycle.
  - Throughput is 1 point per cycle with out_ready held high.
- Width rules:
  - EW must hold |E| <= 3*(2^CW)^2; the default satisfies this.
  - x/y counters are CW+1 bits so that xmax = 2^CW-1 does not wrap.
- Boundaries:
  - in_valid while busy is ignored; in_ready=0.
  - out_ready may be held low indefinitely.
  - Vertex order is irrelevant; both windings give identical output.
  - pt_count holds its value after done until the next accept.

Test Plan:
- CW=3, vertices (0,0),(4,0),(0,4), edge_incl=1, out_ready=1 -> 15 points in raster order, (0,0)..(4,0), (0,1)..(3,1), ..., (0,4); done pulse; pt_count=15.
- Same vertices with edge_incl=0 -> exactly (1,1),(2,1),(1,2); pt_count=3. Vertices reversed to (0,4),(4,0),(0,0) -> identical output sequence.
- Degenerate (0,0),(2,2),(4,4), and also (5,5)x3 -> no out_valid; done at accept+2; pt_count=0.
- Backpressure: triangle 1 with out_ready low for 3 cycles on the 2nd point -> xo/yo stay (1,0) with out_valid=1 during the stall; no point is skipped or duplicated; total is still 15.
- CW=4, (0,0),(15,0),(0,15), incl -> 136 points; last point (0,15); no wrap at x=15.
- reset_n pulsed low during SCAN of triangle 1 -> outputs clear immediately; in_ready=1 after release; a new job runs correctly.
